// File: rtl/iopipe_egress_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// iopipe_egress_arbiter_pkg
// Shared ASP definitions for the kernel I/O pipe egress path:
//   IO_PIPES_NUM_CHAN    - number of kernel-side I/O pipe channels
//   SHIM_AVST_DATA_WIDTH - Avalon-ST data width of the host/network path
//   IOPIPE_CHAN_W        - width of a channel index
//   iopipe_arb_state_t   - egress arbiter FSM states
// ---------------------------------------------------------------------------
package iopipe_egress_arbiter_pkg;

    localparam int IO_PIPES_NUM_CHAN    = 16;
    localparam int SHIM_AVST_DATA_WIDTH = 64;
    localparam int IOPIPE_CHAN_W        = $clog2(IO_PIPES_NUM_CHAN);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } iopipe_arb_state_t;

endpackage

// File: rtl/iopipe_egress_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// iopipe_rr_pick
// Combinational circular priority picker, reusable by any ASP arbiter.
// Returns the first set bit of req found by searching upward from
// last_grant+1 and wrapping from NUM_CHAN-1 back to 0.
// Ports:
//   req        in  NUM_CHAN  request vector
//   last_grant in  CHAN_W    most recently served index
//   grant      out CHAN_W    selected index (0 when any=0)
//   any        out 1         at least one request is pending
// ---------------------------------------------------------------------------
module iopipe_rr_pick #(
    parameter int NUM_CHAN = 16,
    parameter int CHAN_W   = $clog2(NUM_CHAN)
) (
    input  logic [NUM_CHAN-1:0] req,
    input  logic [CHAN_W-1:0]   last_grant,
    output logic [CHAN_W-1:0]   grant,
    output logic                any
);

    logic [CHAN_W-1:0] idx_s;
    logic              hit_s;

    // Walk the channels in priority order; the first hit wins and is kept.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int off = 1; off <= NUM_CHAN; off++) begin
            idx_s = CHAN_W'((int'(last_grant) + off) % NUM_CHAN);
            hit_s = ~any & req[idx_s];
            grant = hit_s ? idx_s : grant;
            any   = any | hit_s;
        end
    end

endmodule

// File: rtl/iopipe_egress_arbiter.sv
// ---------------------------------------------------------------------------
// iopipe_egress_arbiter
// Shares one Avalon-ST egress stream among NUM_CHAN kernel I/O pipe channels
// using packet-granular round-robin arbitration (grant held sop..eop).
// Output beats are registered and tagged with their source channel.
// Optional statistics are built when IOPIPE_ARB_STATS_EN is defined.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   chan_enable[NUM_CHAN] CSR arbitration enable, only sampled while idle
//   in_valid/in_sop/in_eop/in_data/in_ready  per-channel sink interface
//   out_valid/out_data/out_sop/out_eop/out_chan/out_ready  egress source
//   busy                  a packet is in flight
//   stats_sel, stats_pkt_count, stats_stall_count (IOPIPE_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module iopipe_egress_arbiter
    import iopipe_egress_arbiter_pkg::*;
#(
    parameter int NUM_CHAN = IO_PIPES_NUM_CHAN,
    parameter int DATA_W   = SHIM_AVST_DATA_WIDTH,
    parameter int CHAN_W   = $clog2(NUM_CHAN)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CHAN-1:0]        chan_enable,
    input  logic [NUM_CHAN-1:0]        in_valid,
    input  logic [NUM_CHAN*DATA_W-1:0] in_data,
    input  logic [NUM_CHAN-1:0]        in_sop,
    input  logic [NUM_CHAN-1:0]        in_eop,
    output logic [NUM_CHAN-1:0]        in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [CHAN_W-1:0]          out_chan,
    input  logic                       out_ready,
    output logic                       busy
`ifdef IOPIPE_ARB_STATS_EN
    ,
    input  logic [CHAN_W-1:0]          stats_sel,
    output logic [31:0]                stats_pkt_count,
    output logic [31:0]                stats_stall_count
`endif
);

    iopipe_arb_state_t    state_r;
    iopipe_arb_state_t    next_state_s;
    logic [CHAN_W-1:0]    grant_r;
    logic [CHAN_W-1:0]    last_grant_r;
    logic [NUM_CHAN-1:0]  req_s;
    logic [NUM_CHAN-1:0]  in_ready_s;
    logic [CHAN_W-1:0]    pick_grant_s;
    logic                 pick_any_s;
    logic                 accept_s;
    logic                 grant_sop_s;
    logic                 grant_eop_s;
    logic [DATA_W-1:0]    grant_data_s;
    logic [DATA_W-1:0]    in_data_a [NUM_CHAN];
    logic                 out_valid_r;
    logic [DATA_W-1:0]    out_data_r;
    logic                 out_sop_r;
    logic                 out_eop_r;
    logic [CHAN_W-1:0]    out_chan_r;

    // Slice the flat data bus into one word per channel.
    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_unpack
        assign in_data_a[c] = in_data[c*DATA_W +: DATA_W];
    end

    iopipe_rr_pick #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
    ) u_pick (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (pick_grant_s),
        .any        (pick_any_s)
    );

    // Request mask, granted-channel handshake and next-state decode.
    always_comb begin
        req_s      = in_valid & chan_enable;
        in_ready_s = '0;
        if (state_r == ARB_BUSY) begin
            // Ready whenever the output register is empty or draining now.
            in_ready_s[grant_r] = ~out_valid_r | out_ready;
        end else begin
            in_ready_s = '0;
        end
        accept_s     = in_valid[grant_r] & in_ready_s[grant_r];
        grant_sop_s  = in_sop[grant_r];
        grant_eop_s  = in_eop[grant_r];
        grant_data_s = in_data_a[grant_r];
        next_state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    next_state_s = ARB_BUSY;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (accept_s && grant_eop_s) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_BUSY;
                end
            end
            default: next_state_s = ARB_IDLE;
        endcase
    end

    // Arbitration state: FSM, current grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ARB_IDLE;
            grant_r      <= '0;
            last_grant_r <= CHAN_W'(NUM_CHAN - 1);
        end else begin
            state_r <= next_state_s;
            if (state_r == ARB_IDLE && pick_any_s) begin
                grant_r <= pick_grant_s;
            end else begin
                grant_r <= grant_r;
            end
            if (accept_s && grant_eop_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Egress register: load on accept, empty once downstream takes the beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_chan_r  <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sop_r   <= grant_sop_s;
            out_eop_r   <= grant_eop_s;
            out_chan_r  <= grant_r;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sop   = out_sop_r;
    assign out_eop   = out_eop_r;
    assign out_chan  = out_chan_r;
    assign busy      = (state_r == ARB_BUSY);

`ifdef IOPIPE_ARB_STATS_EN
    logic [31:0] pkt_cnt_r [NUM_CHAN];
    logic [31:0] stall_cnt_r;
    logic [31:0] stats_pkt_count_r;
    logic [31:0] stats_stall_count_r;

    // Per-channel packet counters (wrap) and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                pkt_cnt_r[c] <= 32'd0;
            end
            stall_cnt_r <= 32'd0;
        end else begin
            if (accept_s && grant_eop_s) begin
                pkt_cnt_r[grant_r] <= pkt_cnt_r[grant_r] + 32'd1;
            end else begin
                pkt_cnt_r[grant_r] <= pkt_cnt_r[grant_r];
            end
            if (out_valid_r && !out_ready && stall_cnt_r != 32'hFFFF_FFFF) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Registered read port; out-of-range selects read as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stats_pkt_count_r   <= 32'd0;
            stats_stall_count_r <= 32'd0;
        end else begin
            if (int'(stats_sel) < NUM_CHAN) begin
                stats_pkt_count_r <= pkt_cnt_r[stats_sel];
            end else begin
                stats_pkt_count_r <= 32'd0;
            end
            stats_stall_count_r <= stall_cnt_r;
        end
    end

    assign stats_pkt_count   = stats_pkt_count_r;
    assign stats_stall_count = stats_stall_count_r;
`endif

endmodule

// File: doc/iopipe_egress_arbiter.md
Name: iopipe_egress_arbiter

Overview:
- Shares one 64-bit Avalon-ST egress stream among IO_PIPES_NUM_CHAN (16) kernel-side I/O pipe channels.
- Sits between the kernel-system I/O pipe outputs and the ASP's single host/network egress path.
- Round-robin arbitration with packet granularity: a grant is held from sop to eop. A per-channel enable mask is driven by ASP CSRs.
- Output is registered, and the granted channel index is tagged on the output.

Parameters:
NUM_CHAN, 16 (IO_PIPES_NUM_CHAN), number of requesting channels, 2..32
DATA_W, 64 (SHIM_AVST_DATA_WIDTH), AVST data width
CHAN_W, $clog2(NUM_CHAN), width of the channel tag

Ports:
clk  in  1  ASP clock
reset_n  in  1  synchronous active-low reset
chan_enable  in  NUM_CHAN  per-channel arbitration enable (CSR)
in_valid  in  NUM_CHAN  per-channel valid
in_data  in  NUM_CHAN*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
in_sop  in  NUM_CHAN  start of packet
in_eop  in  NUM_CHAN  end of packet
in_ready  out  NUM_CHAN  per-channel ready
out_valid  out  1  egress valid
out_data  out  DATA_W  egress data
out_sop  out  1  egress sop
out_eop  out  1  egress eop
out_chan  out  CHAN_W  source channel of current beat
out_ready  in  1  egress ready (downstream backpressure)
busy  out  1  a packet is in flight (state BUSY)

Behaviour:
- Reset (reset_n sampled low on a clk edge):
  - out_valid=0; out_data/out_sop/out_eop/out_chan=0; in_ready=0; busy=0.
  - state=IDLE; grant=0; last_grant=NUM_CHAN-1, so channel 0 has first priority after reset.
- Request vector: req = in_valid & chan_enable.
- FSM states:
  - IDLE: if req != 0, pick the first set bit searching circularly from last_grant+1. Register it as grant, go to BUSY. in_ready stays 0 in IDLE, so one arbitration bubble per packet. If req == 0, stay.
  - BUSY: in_ready[grant] = (!out_valid | out_ready); all other in_ready bits = 0.
    - accept = in_valid[grant] & in_ready[grant].
    - On accept: load the output register with data/sop/eop of channel grant, set out_valid=1, out_chan=grant.
    - When an accepted beat has in_eop=1: last_grant<=grant, go to IDLE in the same cycle.
- Output register: if out_valid & out_ready & no new accept, then out_valid<=0. Latency is 1 cycle from accept to out_valid. Throughput is 1 beat/cycle within a packet.
- Lock rule: the grant is never preempted mid-packet.
  - Deasserting chan_enable[grant] in BUSY does not release the grant; the packet completes.
  - Enable is sampled only in IDLE.
- sop/eop pass through unmodified. The block does not police them.
  - A beat with both sop and eop is a one-beat packet.
  - A missing sop at packet start is forwarded as-is.
- A channel whose in_valid drops mid-packet stalls the arbiter in BUSY. There is no timeout.
- Only one channel requesting: it is re-granted after each eop, with one bubble cycle between packets.
- Circular search wraps from NUM_CHAN-1 to 0.
- Reset mid-packet: all state clears immediately and the partial packet is dropped. Upstream is reset by the same reset_n.

Optional Feature:
- Macro: IOPIPE_ARB_STATS_EN.
- When defined, add:
  - Input stats_sel [CHAN_W].
  - Output stats_pkt_count [32]: packets (eop beats) forwarded for channel stats_sel. Counters are per-channel, increment on accept of an eop beat, wrap at 2^32, and reset to 0.
  - Output stats_stall_count [32]: cycles with out_valid & !out_ready. Saturates at 2^32-1 and resets to 0.
  - Both outputs are registered with 1-cycle read latency.
- When not defined: these ports and counters do not exist. Arbitration behaviour is identical in both cases.

Decomposition:
- The shared ASP package holds:
  - IO_PIPES_NUM_CHAN and SHIM_AVST_DATA_WIDTH (existing).
  - A new IOPIPE_CHAN_W = $clog2(IO_PIPES_NUM_CHAN).
  - A new typedef enum logic {ARB_IDLE, ARB_BUSY} iopipe_arb_state_t.
- One sub-module: iopipe_rr_pick, a combinational circular priority picker with inputs req and last_grant and outputs grant and any. It is reusable by other ASP arbiters.

Test Plan:
- Reset, then ch0 and ch3 each send a 3-beat packet simultaneously, chan_enable=all 1s, out_ready=1:
  - ch0 packet is output first, out_chan=0; first out_valid appears 2 cycles after the request (1 arbitration + 1 register).
  - 1 bubble, then ch3 packet with out_chan=3.
- All 16 channels continuously request single-beat packets: grant order is 0,1,…,15,0. No channel is granted twice before every other requester is served.
- ch5 mid-packet; drop chan_enable[5] after beat 1 of 4:
  - all 4 beats are forwarded.
  - ch5 is not re-granted while disabled, even with in_valid[5]=1.
- out_ready held 0 for 5 cycles mid-packet: out_valid and out_data stay stable, in_ready[grant]=0. On release, beats resume in order with no loss and no duplication.
- reset_n pulsed low during beat 2 of an 8-beat ch7 packet: next cycle out_valid=0, in_ready=0, busy=0. Next arbitration starts from ch0.
- IOPIPE_ARB_STATS_EN defined:
  - 10 packets on ch2 → stats_sel=2 reads stats_pkt_count=10.
  - 5 stall cycles → stats_stall_count=5.
